// File: rtl/tf_rom_loader_pkg.sv
// Shared constants and state encoding for the twiddle-factor ROM loader.
package tf_rom_loader_pkg;

  localparam int unsigned LANE_W    = 14;
  localparam int unsigned LANES     = 8;
  localparam int unsigned DATA_W    = 112;
  localparam int unsigned TF_DEPTH  = 319;
  localparam int unsigned TF_ADDR_W = 9;

  // The ROM word must hold exactly one coefficient per BFU lane.
  localparam bit TF_WIDTH_OK = (DATA_W == LANES * LANE_W);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } tf_state_e;

endpackage

// File: rtl/tf_lane_packer.sv
// Lane counter and packing register: gathers lanes coefficients into one ROM word.
module tf_lane_packer
  import tf_rom_loader_pkg::*;
#(
  parameter int unsigned lanes      = LANES,
  parameter int unsigned lane_width = LANE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_accept,
  input  logic [lane_width-1:0]         i_data,
  output logic                          o_word_ready,
  output logic [lanes*lane_width-1:0]   o_word
);

  localparam int unsigned CntW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(lanes - 1);

  logic [CntW-1:0]             r_lane;
  logic [lanes*lane_width-1:0] r_pack;
  logic [lanes*lane_width-1:0] w_word;

  // Current beat merged into its lane so the completed word is visible in the accept cycle.
  always_comb begin
    w_word = r_pack;
    w_word[32'(r_lane) * lane_width +: lane_width] = i_data;
  end

  assign o_word_ready = i_accept && (r_lane == LastLane);
  assign o_word       = w_word;

  // Lane counter and packing register update on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_pack <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (i_accept) begin
      r_pack <= w_word;
      r_lane <= (r_lane == LastLane) ? '0 : r_lane + CntW'(1);
    end
  end

endmodule

// File: rtl/tf_rom_loader.sv
// Streams twiddle coefficients into the ROM: packs lanes per word, issues one write per word.
module tf_rom_loader
  import tf_rom_loader_pkg::*;
#(
  parameter int unsigned addr_rom_width = TF_ADDR_W,
  parameter int unsigned data_width     = DATA_W,
  parameter int unsigned depth_rom      = TF_DEPTH,
  parameter int unsigned lane_width     = LANE_W,
  parameter int unsigned lanes          = LANES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      s_valid,
  input  logic [lane_width-1:0]     s_data,
  output logic                      s_ready,
  output logic [addr_rom_width-1:0] A,
  output logic [data_width-1:0]     D,
  output logic                      EN,
  output logic                      REN,
  output logic                      busy,
  output logic                      done
);

  if (!TF_WIDTH_OK || (data_width != lanes * lane_width) ||
      (depth_rom > (1 << addr_rom_width)) || (depth_rom == 0)) begin : g_param_check
    $error("tf_rom_loader: inconsistent word width or depth parameters");
  end

  localparam logic [addr_rom_width-1:0] LastAddr = addr_rom_width'(depth_rom - 1);

  tf_state_e                 r_state, w_state_d;
  logic [addr_rom_width-1:0] r_word, w_word_d;
  logic [addr_rom_width-1:0] r_a, w_a_d;
  logic [data_width-1:0]     r_d, w_d_d;
  logic                      r_ready, w_ready_d;
  logic                      r_en, w_en_d;
  logic                      r_ren, w_ren_d;
  logic                      r_busy, w_busy_d;
  logic                      r_done, w_done_d;
  logic                      w_clear;
  logic                      w_accept;
  logic                      w_word_ready;
  logic [data_width-1:0]     w_packed;

  assign w_accept = s_valid && r_ready;

  tf_lane_packer #(
    .lanes      (lanes),
    .lane_width (lane_width)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_data       (s_data),
    .o_word_ready (w_word_ready),
    .o_word       (w_packed)
  );

  // Next-state, word counter and next values of every registered output.
  always_comb begin
    w_state_d = r_state;
    w_word_d  = r_word;
    w_a_d     = r_a;
    w_d_d     = r_d;
    w_ready_d = r_ready;
    w_en_d    = 1'b0;
    w_ren_d   = 1'b1;
    w_clear   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ready_d = 1'b0;
        if (start) begin
          w_state_d = StLoad;
          w_word_d  = '0;
          w_ready_d = 1'b1;
          w_clear   = 1'b1;
        end
      end
      StLoad: begin
        if (w_word_ready) begin
          w_en_d  = 1'b1;
          w_ren_d = 1'b0;
          w_a_d   = r_word;
          w_d_d   = w_packed;
          // Final word: stop accepting now; the counter holds at the last address.
          if (r_word == LastAddr) begin
            w_ready_d = 1'b0;
          end else begin
            w_word_d = r_word + addr_rom_width'(1);
          end
        end
        if (r_en && (r_a == LastAddr)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_ready_d = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_ready_d = 1'b0;
        w_state_d = StIdle;
      end
    endcase
    w_busy_d = (w_state_d == StLoad);
    w_done_d = (w_state_d == StDone);
  end

  // State and output registers; reset also suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_a     <= '0;
      r_d     <= '0;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_ren   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_word  <= w_word_d;
      r_a     <= w_a_d;
      r_d     <= w_d_d;
      r_ready <= w_ready_d;
      r_en    <= w_en_d;
      r_ren   <= w_ren_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign s_ready = r_ready;
  assign A       = r_a;
  assign D       = r_d;
  assign EN      = r_en;
  assign REN     = r_ren;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_tf_rom_loader.sv
// Self-checking bench for tf_rom_loader: default-depth instance plus a depth-4 instance.
module tb_tf_rom_loader;

  localparam int NWORDS = 319;
  localparam int NBEATS = NWORDS * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, s_valid, s_ready, EN, REN, busy, done;
  logic [13:0]  s_data;
  logic [8:0]   A;
  logic [111:0] D;

  logic         rst2, start2, s_valid2, s_ready2, EN2, REN2, busy2, done2;
  logic [13:0]  s_data2;
  logic [8:0]   A2;
  logic [111:0] D2;

  tf_rom_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .A(A), .D(D), .EN(EN), .REN(REN), .busy(busy), .done(done)
  );

  tf_rom_loader #(.depth_rom(4)) u_small (
    .clk(clk), .rst(rst2), .start(start2), .s_valid(s_valid2), .s_data(s_data2),
    .s_ready(s_ready2), .A(A2), .D(D2), .EN(EN2), .REN(REN2), .busy(busy2), .done(done2)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference stimulus and model: word w = concatenation of beats w*8..w*8+7, lane 0 at LSB.
  logic [13:0] beats  [0:NBEATS-1];
  logic [13:0] beats2 [0:63];

  function automatic logic [111:0] exp_word(input int w);
    logic [111:0] r = '0;
    for (int j = 0; j < 8; j++) r = r | (112'(beats[w*8+j]) << (14 * j));
    return r;
  endfunction

  function automatic logic [111:0] exp_word2(input int w);
    logic [111:0] r = '0;
    for (int j = 0; j < 8; j++) r = r | (112'(beats2[w*8+j]) << (14 * j));
    return r;
  endfunction

  // ROM-port monitor, sampled on the falling edge.
  int           cyc = 0;
  logic [8:0]   wr_a [$];
  logic [111:0] wr_d [$];
  int           wr_cyc [$];
  int           done_cnt, done_cyc, acc_cnt, ren_bad;
  bit           pipe_seen, pipe_acc;
  logic [8:0]   wr2_a [$];
  logic [111:0] wr2_d [$];
  int           done2_cnt, acc2_cnt;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (EN === 1'b1) begin
      wr_a.push_back(A);
      wr_d.push_back(D);
      wr_cyc.push_back(cyc);
      if (REN !== 1'b0) ren_bad++;
      if (A == 9'd0 && !pipe_seen) begin
        pipe_seen = 1'b1;
        pipe_acc  = s_valid && s_ready;
      end
    end else if (REN !== 1'b1) begin
      ren_bad++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_valid && s_ready) acc_cnt++;
    if (EN2 === 1'b1) begin
      wr2_a.push_back(A2);
      wr2_d.push_back(D2);
    end
    if (done2 === 1'b1) done2_cnt++;
    if (s_valid2 && s_ready2) acc2_cnt++;
  end

  task automatic clear_mon();
    wr_a.delete(); wr_d.delete(); wr_cyc.delete();
    done_cnt = 0; done_cyc = 0; acc_cnt = 0; ren_bad = 0;
    pipe_seen = 1'b0; pipe_acc = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("ready_after_start", s_ready, 1'b1);
  endtask

  // Drives beats in order, each held until accepted; optional gaps, stall, stray start, reset.
  task automatic stream(input int n_beats, input int idle_pct, input int stall_at,
                        input int start_at, input int rst_at);
    int  i = 0;
    int  guard = 0;
    bit  stalled = 1'b0;
    bit  acc;
    while (i < n_beats && guard < 20000) begin
      if (i == rst_at) begin
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (!stalled && i == stall_at) begin
        s_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        stalled = 1'b1;
      end
      start   = (i == start_at);
      s_valid = ($urandom_range(99) >= idle_pct);
      s_data  = beats[i];
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    check("stream_budget", guard < 20000, 1'b1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && done_cnt == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_session(input string pre);
    int n;
    check({pre, "_wr_count"}, wr_a.size(), NWORDS);
    n = (wr_a.size() < NWORDS) ? wr_a.size() : NWORDS;
    for (int w = 0; w < n; w++) begin
      check($sformatf("%s_addr_w%0d", pre, w), wr_a[w], w);
      check($sformatf("%s_data_w%0d", pre, w), wr_d[w], exp_word(w));
    end
    check({pre, "_ren_during_en"}, ren_bad, 0);
    check({pre, "_done_count"}, done_cnt, 1);
    if (wr_cyc.size() > 0) check({pre, "_done_latency"}, done_cyc - wr_cyc[$], 1);
    check({pre, "_beats_accepted"}, acc_cnt, NBEATS);
    check({pre, "_ready_end"}, s_ready, 1'b0);
    check({pre, "_busy_end"}, busy, 1'b0);
    check({pre, "_done_end"}, done, 1'b0);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    rst2 = 1'b1; start2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check("rst_s_ready", s_ready, 1'b0);
    check("rst_A", A, 9'd0);
    check("rst_D", D, 112'd0);
    check("rst_EN", EN, 1'b0);
    check("rst_REN", REN, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Full back-to-back load with lane j of word w = (w*8+j) mod 3329.
    for (int i = 0; i < NBEATS; i++) beats[i] = 14'(i % 3329);
    clear_mon();
    pulse_start();
    stream(NBEATS, 0, -1, -1, -1);
    wait_done();
    check_session("s1");
    check("pipe_accept_during_write0", pipe_acc, 1'b1);
    // Beats offered after the session must not be taken.
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("s1_no_extra_accept", acc_cnt, NBEATS);

    // Random idle cycles, a 20-cycle stall inside word 50, stray start at word 100.
    clear_mon();
    pulse_start();
    stream(NBEATS, 40, 50 * 8 + 3, 100 * 8, -1);
    wait_done();
    check_session("s2");

    // Random data, reset after word 5 lane 3.
    for (int i = 0; i < NBEATS; i++) beats[i] = 14'($urandom);
    clear_mon();
    pulse_start();
    stream(NBEATS, 0, -1, -1, 5 * 8 + 4);
    check("rstmid_EN", EN, 1'b0);
    check("rstmid_REN", REN, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ready", s_ready, 1'b0);
    check("rstmid_wr_count", wr_a.size(), 5);
    for (int w = 0; w < 5 && w < wr_a.size(); w++) begin
      check($sformatf("rstmid_data_w%0d", w), wr_d[w], exp_word(w));
    end
    clear_mon();
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("idle_no_write", wr_a.size(), 0);
    check("idle_no_accept", acc_cnt, 0);

    // Reload after reset with fresh random data, starting again from A=0, lane 0.
    for (int i = 0; i < NBEATS; i++) beats[i] = 14'($urandom);
    clear_mon();
    pulse_start();
    stream(NBEATS, 20, -1, -1, -1);
    wait_done();
    check_session("s4");

    // Depth-4 instance: exactly 32 beats, writes to 0..3, then idle.
    for (int i = 0; i < 64; i++) beats2[i] = 14'($urandom);
    wr2_a.delete(); wr2_d.delete(); done2_cnt = 0; acc2_cnt = 0;
    rst2 = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    k = 0;
    for (int c = 0; c < 60; c++) begin
      s_valid2 = 1'b1;
      s_data2  = beats2[k];
      @(negedge clk);
      if (s_valid2 && s_ready2) k++;
      @(posedge clk); #1;
    end
    s_valid2 = 1'b0;
    check("d4_beats_accepted", acc2_cnt, 32);
    check("d4_wr_count", wr2_a.size(), 4);
    for (int w = 0; w < 4 && w < wr2_a.size(); w++) begin
      check($sformatf("d4_addr_w%0d", w), wr2_a[w], w);
      check($sformatf("d4_data_w%0d", w), wr2_d[w], exp_word2(w));
    end
    check("d4_done_count", done2_cnt, 1);
    check("d4_ready_end", s_ready2, 1'b0);
    check("d4_busy_end", busy2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tf_rom_loader.md
Name: tf_rom_loader

Overview:
- Write-side companion of the twiddle-factor ROM used by the radix-2, 8-BFU NTT datapath.
- Accepts twiddle coefficients one lane per beat on a valid/ready stream and packs 8 lanes into one ROM word.
- Issues sequential ROM write cycles (EN=1, REN=0) for addresses 0..depth_rom-1, then signals done.
- Sits between the host/DMA coefficient stream and the ROM's A/D/EN/REN port.

Parameters:
- addr_rom_width, 9: ROM address width.
- data_width, 112: ROM word width. Must equal lanes*lane_width.
- depth_rom, 319: number of ROM words to load per session.
- lane_width, 14: bits per twiddle coefficient.
- lanes, 8: coefficients per ROM word, one per BFU.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load session; honoured only in IDLE.
- s_valid  in  1  input beat valid.
- s_data  in  lane_width  twiddle coefficient.
- s_ready  out  1  loader can accept a beat.
- A  out  addr_rom_width  ROM address.
- D  out  data_width  ROM write data.
- EN  out  1  ROM enable.
- REN  out  1  ROM read-enable; 0 = write.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse after the final ROM write.

Behaviour:
- Reset values: s_ready=0, A=0, D=0, EN=0, REN=1, busy=0, done=0. State is IDLE; lane and word counters are 0. All outputs are registered.
- States and transitions:
  - IDLE: start=1 → LOAD. Lane counter and word counter clear.
  - LOAD: busy=1. s_ready=1 while the number of accepted words is below depth_rom.
  - LOAD → DONE: in the cycle after the final word's write is issued.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- Beat acceptance and packing:
  - A beat is accepted when s_valid & s_ready.
  - Lane k (k = 0..lanes-1 within the word) lands in bits [k*lane_width +: lane_width]. The first beat of a word is the LSB lane.
- Write issue:
  - When the beat completing lane lanes-1 is accepted in cycle t, cycle t+1 drives EN=1, REN=0, A=word index, D=packed word.
  - Write latency is therefore 1 cycle after the last lane.
  - Exactly one write pulse per word.
  - In every other cycle: EN=0, REN=1. A and D hold their last values.
- Throughput: one beat per cycle, no bubbles. A new word's lane 0 may be accepted in the same cycle the previous word's write is on the ROM port; the packing register and D register are separate.
- Word counter: addr_rom_width bits, increments on each write issue.
  - After the write to address depth_rom-1, s_ready drops. It is already low in cycle t+1, because it is deasserted on acceptance of the final beat.
  - No address wrap: the counter never exceeds depth_rom-1.
- s_valid low during LOAD: lanes stall. Partial packing is retained indefinitely; there is no timeout.
- start outside IDLE: ignored. No restart and no counter clear.
- Beats while not in LOAD: s_ready=0, so nothing is accepted.
- Reset mid-operation: returns to IDLE with the reset values above, and the partial word is discarded. Writes already issued stay in the ROM. A reset asserted in the same cycle as a pending write suppresses that write (EN=0).

Decomposition:
- Shared package:
  - LANE_W=14, LANES=8, DATA_W=112, TF_DEPTH=319, TF_ADDR_W=9.
  - State encoding: IDLE, LOAD, DONE.
  - Elaboration check that DATA_W == LANES*LANE_W.
- Sub-module tf_lane_packer:
  - Lane counter plus packing register.
  - Inputs: beat-accept strobe, s_data.
  - Outputs: word_ready strobe, packed word.
  - The top level owns the FSM, word counter and ROM-port registers.

Test Plan:
- Full load, back-to-back valid, defaults. Lane j of word w = (w*8+j) mod 3329.
  - ROM write to address w holds those values, lane 0 at [13:0].
  - 319 EN pulses with REN=0; addresses 0..318 in order.
  - done pulses once, 1 cycle after the write to 318.
  - Total 2552 beats accepted, then s_ready=0.
- Random s_valid gaps (~40% idle):
  - Identical ROM contents to the back-to-back run.
  - Never two EN pulses for one word.
  - Partial word survives 20-cycle stalls.
- Pipelining check: lane 7 of word 0 in cycle t, lane 0 of word 1 in cycle t+1.
  - EN=1 at t+1 with A=0 while the new beat is accepted.
  - Word 1 is unaffected.
- start pulsed at word 100:
  - Ignored; counters continue; done fires once at the end.
- rst asserted after word 5, lane 3:
  - Next cycle: EN=0, REN=1, busy=0, s_ready=0.
  - On start, reload restarts at A=0 with lane 0.
  - Words 0..4 are not rewritten until reached again.
- depth_rom=4:
  - Exactly 32 beats accepted, writes to A=0..3, done, back to IDLE.
  - Extra s_valid beats are not accepted.
